// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus for the boot program loader.
//
// Signals:
//   byte_i        host -> loader  incoming stream byte
//   byte_valid_i  host -> loader  byte_i holds a valid byte
//   byte_ready_o  loader -> host  loader accepts a byte this cycle
//   pm_we_o       loader -> mem   one-cycle instruction-memory write strobe
//   pm_addr_o     loader -> mem   word address of the write
//   pm_data_o     loader -> mem   instruction word of the write
//
// Modports:
//   master : host/memory side (drives the byte stream, observes the writes)
//   slave  : the loader itself
interface program_loader_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [7:0]            byte_i;
  logic                  byte_valid_i;
  logic                  byte_ready_o;
  logic                  pm_we_o;
  logic [ADDR_WIDTH-1:0] pm_addr_o;
  logic [31:0]           pm_data_o;

  modport master (
    output byte_i,
    output byte_valid_i,
    input  byte_ready_o,
    input  pm_we_o,
    input  pm_addr_o,
    input  pm_data_o
  );

  modport slave (
    input  byte_i,
    input  byte_valid_i,
    output byte_ready_o,
    output pm_we_o,
    output pm_addr_o,
    output pm_data_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader for the pipelined MIPS core.
//
// Accepts a byte stream  LEN_HI LEN_LO {4*N data bytes} CHK  over a
// valid/ready handshake, packs data bytes big-endian into 32-bit words and
// writes them to consecutive instruction-memory addresses starting at 0.
// The core is held in reset until an image whose XOR checksum matches has
// been fully written.
//
// Ports:
//   clk             single clock, rising edge
//   reset           synchronous active-high reset
//   start_i         one-cycle re-arm pulse, honoured only in DONE or ERROR
//   bus             byte stream in / program-memory write out (slave modport)
//   cpu_reset_o     reset to MIPS_Processor, high in every state but DONE
//   done_o          image loaded and checksum matched
//   error_o         image rejected (length too large or checksum mismatch)
//   words_loaded_o  number of completed word writes since the last re-arm
module program_loader #(
  parameter int MEMORY_DEPTH = 64,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  program_loader_if.slave     bus,
  output logic                cpu_reset_o,
  output logic                done_o,
  output logic                error_o,
  output logic [ADDR_WIDTH:0] words_loaded_o
);

  localparam logic [15:0] DEPTH_16 = 16'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [23:0]           asm_reg, asm_next;       // first three bytes of the word in flight
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  logic [7:0]            acc_reg, acc_next;       // running XOR of data bytes
  logic                  pm_we_reg, pm_we_next;
  logic [ADDR_WIDTH-1:0] pm_addr_reg, pm_addr_next;
  logic [31:0]           pm_data_reg, pm_data_next;
  logic [ADDR_WIDTH:0]   words_reg, words_next;   // also serves as the next word address

  logic accept;
  logic last_word;

  // Ready depends on state only, never on byte_valid_i.
  assign bus.byte_ready_o = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                            (state_reg == S_DATA)   || (state_reg == S_CHECK);
  assign accept           = bus.byte_valid_i && bus.byte_ready_o;
  assign last_word        = (16'(words_reg) + 16'd1) == len_reg;

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    asm_next      = asm_reg;
    byte_cnt_next = byte_cnt_reg;
    acc_next      = acc_reg;
    pm_we_next    = 1'b0;
    pm_addr_next  = pm_addr_reg;
    pm_data_next  = pm_data_reg;
    words_next    = words_reg;

    case (state_reg)
      S_LEN_HI: begin
        if (accept) begin
          len_next   = {bus.byte_i, len_reg[7:0]};
          state_next = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_next = {len_reg[15:8], bus.byte_i};
          if (len_next > DEPTH_16) begin
            state_next = S_ERROR;
          end else if (len_next == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          acc_next      = acc_reg ^ bus.byte_i;
          asm_next      = {asm_reg[15:0], bus.byte_i};
          byte_cnt_next = byte_cnt_reg + 2'd1;     // wraps to 0 after the 4th byte
          if (byte_cnt_reg == 2'd3) begin
            pm_we_next   = 1'b1;
            pm_addr_next = words_reg[ADDR_WIDTH-1:0];
            pm_data_next = {asm_reg, bus.byte_i};
            words_next   = words_reg + 1'b1;
            if (last_word) begin
              state_next = S_CHECK;
            end
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_next = (bus.byte_i == acc_reg) ? S_DONE : S_ERROR;
        end
      end

      S_DONE, S_ERROR: begin
        // words_loaded is deliberately kept through ERROR and only cleared here.
        if (start_i) begin
          state_next    = S_LEN_HI;
          len_next      = 16'd0;
          asm_next      = 24'd0;
          byte_cnt_next = 2'd0;
          acc_next      = 8'd0;
          words_next    = '0;
        end
      end

      default: begin
        state_next = S_LEN_HI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_LEN_HI;
      len_reg      <= 16'd0;
      asm_reg      <= 24'd0;
      byte_cnt_reg <= 2'd0;
      acc_reg      <= 8'd0;
      pm_we_reg    <= 1'b0;
      pm_addr_reg  <= '0;
      pm_data_reg  <= 32'd0;
      words_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      asm_reg      <= asm_next;
      byte_cnt_reg <= byte_cnt_next;
      acc_reg      <= acc_next;
      pm_we_reg    <= pm_we_next;
      pm_addr_reg  <= pm_addr_next;
      pm_data_reg  <= pm_data_next;
      words_reg    <= words_next;
    end
  end

  assign bus.pm_we_o    = pm_we_reg;
  assign bus.pm_addr_o  = pm_addr_reg;
  assign bus.pm_data_o  = pm_data_reg;
  assign cpu_reset_o    = (state_reg != S_DONE);
  assign done_o         = (state_reg == S_DONE);
  assign error_o        = (state_reg == S_ERROR);
  assign words_loaded_o = words_reg;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: images are described as word lists,
// the expected writes and final status are derived from the stream rules, and
// a negedge monitor checks every write strobe against a scoreboard queue.
module tb_program_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;
  logic [AW:0] words_loaded_o;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .bus            (bus),
    .cpu_reset_o    (cpu_reset_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          gap_pct = 0;
  int          start_at_byte = -1;
  wr_t         exp_q[$];
  int          write_cycles[$];
  logic [31:0] img_words[$];
  wr_t         mon_e;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pm_we_o === 1'b1) begin
        write_cycles.push_back(cycle);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d data=%h required no write",
                   bus.pm_addr_o, bus.pm_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", 64'(bus.pm_addr_o), 64'(mon_e.addr));
          check("write_data", 64'(bus.pm_data_o), 64'(mon_e.data));
          check("words_at_write", 64'(words_loaded_o), 64'(mon_e.addr) + 64'd1);
          $display("write addr=%0d data=%h", bus.pm_addr_o, bus.pm_data_o);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) begin
      x = x ^ img_words[i][31:24] ^ img_words[i][23:16] ^ img_words[i][15:8] ^ img_words[i][7:0];
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; optional random idle gap before the byte.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if ($urandom_range(99) < gap_pct) begin
      repeat ($urandom_range(1, 3)) tick();
    end
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    while (bus.byte_ready_o !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=ready low required=ready high");
    end else begin
      tick();
    end
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic rearm();
    pulse_start();
    check("rearm_done", 64'(done_o), 64'd0);
    check("rearm_error", 64'(error_o), 64'd0);
    check("rearm_cpu_reset", 64'(cpu_reset_o), 64'd1);
    check("rearm_words", 64'(words_loaded_o), 64'd0);
    check("rearm_ready", 64'(bus.byte_ready_o), 64'd1);
  endtask

  // Sends an image of n declared words (from img_words) followed by chk and
  // checks the final status predicted from the stream rules.
  task automatic run_image(input int n, input logic [7:0] chk, input string tag);
    logic [15:0] n16     = 16'(n);
    logic        len_err = (n > DEPTH);
    logic        exp_done;
    int          nb = 0;
    if (!len_err) begin
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: (AW+1)'(i), data: img_words[i]});
    end
    exp_done = !len_err && (chk == img_xor(n));
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    if (!len_err) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(img_words[i][31-8*k -: 8]);
          if (nb == start_at_byte) pulse_start();
          nb++;
        end
      end
      send_byte(chk);
    end
    repeat (3) tick();
    check({tag, "_done"}, 64'(done_o), 64'(exp_done));
    check({tag, "_error"}, 64'(error_o), 64'(!exp_done));
    check({tag, "_cpu_reset"}, 64'(cpu_reset_o), 64'(!exp_done));
    check({tag, "_words"}, 64'(words_loaded_o), len_err ? 64'd0 : 64'(n));
    check({tag, "_ready_after"}, 64'(bus.byte_ready_o), 64'd0);
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    $display("image %s n=%0d chk=%02h done=%0d error=%0d words=%0d",
             tag, n, chk, done_o, error_o, words_loaded_o);
  endtask

  initial begin
    logic [7:0] good;
    reset            = 1'b1;
    start_i          = 1'b0;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    repeat (2) tick();
    check("rst_pm_we", 64'(bus.pm_we_o), 64'd0);
    check("rst_pm_addr", 64'(bus.pm_addr_o), 64'd0);
    check("rst_pm_data", 64'(bus.pm_data_o), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_words", 64'(words_loaded_o), 64'd0);
    check("rst_ready", 64'(bus.byte_ready_o), 64'd1);
    reset = 1'b0;
    tick();

    // Two-word image, back to back; XOR of these eight bytes is 0x00.
    img_words = '{32'h12345678, 32'h9ABCDEF0};
    write_cycles.delete();
    run_image(2, 8'h00, "basic_good");
    check("write_spacing", 64'(write_cycles.size() == 2 ? write_cycles[1] - write_cycles[0] : 0), 64'd4);

    // Junk offered in DONE must be ignored.
    bus.byte_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.byte_i = 8'($urandom);
      tick();
      check("done_ready_low", 64'(bus.byte_ready_o), 64'd0);
    end
    bus.byte_valid_i = 1'b0;
    check("junk_done", 64'(done_o), 64'd1);
    check("junk_words", 64'(words_loaded_o), 64'd2);
    check("junk_addr", 64'(bus.pm_addr_o), 64'd1);
    check("junk_data", 64'(bus.pm_data_o), 64'h9ABCDEF0);

    rearm();
    run_image(2, 8'h88, "basic_badchk");
    rearm();
    run_image(2, 8'h00, "basic_retry");

    // Oversized length is rejected right after LEN_LO.
    rearm();
    img_words.delete();
    run_image(65, 8'h00, "too_long");

    // Empty image: just a checksum of zero.
    rearm();
    run_image(0, 8'h00, "empty");

    // Full-depth random image with gaps; start_i in LEN_HI and DATA is ignored.
    rearm();
    pulse_start();
    img_words.delete();
    for (int i = 0; i < DEPTH; i++) img_words.push_back($urandom);
    gap_pct       = 30;
    start_at_byte = 5;
    run_image(DEPTH, img_xor(DEPTH), "random_full");
    start_at_byte = -1;

    // Random image with a corrupted checksum.
    rearm();
    img_words.delete();
    for (int i = 0; i < 7; i++) img_words.push_back($urandom);
    good = img_xor(7);
    run_image(7, good ^ 8'($urandom_range(1, 255)), "random_badchk");

    // Reset in the middle of word 1: only word 0 is ever written.
    rearm();
    gap_pct = 0;
    exp_q.push_back('{addr: '0, data: 32'hCAFEF00D});
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hF0);
    send_byte(8'h0D);
    send_byte(8'h11);
    send_byte(8'h22);
    reset   = 1'b1;
    start_i = 1'b1;
    tick();
    reset   = 1'b0;
    start_i = 1'b0;
    check("midrst_pm_we", 64'(bus.pm_we_o), 64'd0);
    check("midrst_pm_addr", 64'(bus.pm_addr_o), 64'd0);
    check("midrst_pm_data", 64'(bus.pm_data_o), 64'd0);
    check("midrst_words", 64'(words_loaded_o), 64'd0);
    check("midrst_cpu_reset", 64'(cpu_reset_o), 64'd1);
    check("midrst_ready", 64'(bus.byte_ready_o), 64'd1);
    check("midrst_pending", 64'(exp_q.size()), 64'd0);
    repeat (6) tick();
    img_words = '{32'hA5C3_0F81};
    gap_pct   = 20;
    run_image(1, img_xor(1), "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
